// File: rtl/frame_arbiter.sv
// frame_arbiter: frame-atomic round-robin merge of NumSrc streams
// into one output, with an APB register bank and end-of-frame irq.
module frame_arbiter #(
  parameter int DataBits = 8,
  parameter int NumSrc   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 cfg_paddr,
  input  logic                       cfg_pwrite,
  input  logic [31:0]                cfg_pwdata,
  input  logic                       cfg_psel,
  input  logic                       cfg_penable,
  output logic                       cfg_pready,
  output logic [31:0]                cfg_prdata,
  output logic                       cfg_pslverr,
  output logic                       cfg_irq,
  input  logic [NumSrc-1:0]          src_valid,
  output logic [NumSrc-1:0]          src_ready,
  input  logic [NumSrc*DataBits-1:0] src_data,
  input  logic [NumSrc-1:0]          src_eof,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DataBits-1:0]        dout_data,
  output logic                       dout_eof
);

  localparam int IW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       last;
  logic [NumSrc-1:0]   enable;
  logic                irq;
  logic [31:0]         prdata;
  logic [31:0]         fcnt [NumSrc];

  logic                busy;
  logic                sel_valid;
  logic                sel_eof;
  logic [DataBits-1:0] sel_data;
  logic                accept_eof;
  logic [NumSrc-1:0]   req;
  logic                found;
  logic [IW-1:0]       pick;
  logic                apb_setup;
  logic                apb_wr;
  logic                apb_rd;
  logic [2:0]          widx;
  logic [31:0]         rdata;
  logic                unused_bits;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int            b
  );
    int s;
    s = int'(a) + b;
    if (s >= NumSrc) s = s - NumSrc;
    return IW'(s);
  endfunction

  assign cfg_pready  = 1'b1;
  assign cfg_pslverr = 1'b0;
  assign cfg_prdata  = prdata;
  assign cfg_irq     = irq;

  assign unused_bits = ^{cfg_paddr[1:0], cfg_pwdata[31:NumSrc]};

  assign busy       = (state == GRANT) && !rst;
  assign req        = src_valid & enable;
  assign accept_eof = busy && sel_valid && sel_eof && dout_ready;

  assign apb_setup = cfg_psel && !cfg_penable;
  assign apb_wr    = apb_setup && cfg_pwrite;
  assign apb_rd    = apb_setup && !cfg_pwrite;
  assign widx      = cfg_paddr[4:2];

  // Mux the granted source onto the shared output path.
  always_comb begin
    sel_valid = 1'b0;
    sel_eof   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (grant == IW'(i)) begin
        sel_valid = src_valid[i];
        sel_eof   = src_eof[i];
        sel_data  = src_data[i*DataBits +: DataBits];
      end
    end
  end

  // Output side and per-source ready; all quiet outside GRANT.
  always_comb begin
    dout_valid = busy && sel_valid;
    dout_data  = busy ? sel_data : '0;
    dout_eof   = busy && sel_eof;
    src_ready  = '0;
    for (int i = 0; i < NumSrc; i++) begin
      src_ready[i] = busy && (grant == IW'(i)) && dout_ready;
    end
  end

  // Round-robin pick: first enabled requester at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 0; off < NumSrc; off++) begin
      if (!found && req[wrap_add(rr_ptr, off)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_ptr, off);
      end
    end
  end

  // Register read decode.
  always_comb begin
    rdata = '0;
    case (widx)
      3'd0: rdata[NumSrc-1:0] = enable;
      3'd1: begin
        rdata[0]   = (state == GRANT);
        rdata[5:4] = grant;
      end
      3'd2: rdata[0] = irq;
      3'd3: rdata[IW-1:0] = last;
      default: begin
        for (int i = 0; i < NumSrc; i++) begin
          if (widx[1:0] == IW'(i)) rdata = fcnt[i];
        end
      end
    endcase
  end

  // Grant FSM, frame statistics, irq and register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      last   <= '0;
      enable <= '1;
      irq    <= 1'b0;
      prdata <= '0;
      for (int i = 0; i < NumSrc; i++) fcnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept_eof) begin
            fcnt[grant] <= fcnt[grant] + 32'd1;
            last        <= grant;
            rr_ptr      <= wrap_add(grant, 1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (apb_wr && widx == 3'd0) enable <= cfg_pwdata[NumSrc-1:0];
      if (accept_eof) begin
        irq <= 1'b1;
      end else if (apb_wr && widx == 3'd2) begin
        irq <= cfg_pwdata[0];
      end
      if (apb_rd) prdata <= rdata;
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// tb_frame_arbiter: directed scoreboard bench for frame_arbiter
// covering round-robin order, masking, backpressure, irq and reset.
module tb_frame_arbiter;

  localparam int DB = 8;
  localparam int NS = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4:0]     cfg_paddr = '0;
  logic           cfg_pwrite = 1'b0;
  logic [31:0]    cfg_pwdata = '0;
  logic           cfg_psel = 1'b0;
  logic           cfg_penable = 1'b0;
  logic           cfg_pready;
  logic [31:0]    cfg_prdata;
  logic           cfg_pslverr;
  logic           cfg_irq;
  logic [NS-1:0]  src_valid = '0;
  logic [NS-1:0]  src_ready;
  logic [NS*DB-1:0] src_data = '0;
  logic [NS-1:0]  src_eof = '0;
  logic           dout_valid;
  logic           dout_ready = 1'b1;
  logic [DB-1:0]  dout_data;
  logic           dout_eof;

  frame_arbiter #(.DataBits(DB), .NumSrc(NS)) dut (
    .clk(clk), .rst(rst),
    .cfg_paddr(cfg_paddr), .cfg_pwrite(cfg_pwrite),
    .cfg_pwdata(cfg_pwdata), .cfg_psel(cfg_psel),
    .cfg_penable(cfg_penable), .cfg_pready(cfg_pready),
    .cfg_prdata(cfg_prdata), .cfg_pslverr(cfg_pslverr),
    .cfg_irq(cfg_irq),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_eof(src_eof),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_eof(dout_eof)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int fr_id    = 0;

  logic [8:0]    sq [NS][$];
  logic [8:0]    exp_q [$];
  logic [NS-1:0] fire = '0;
  logic          prev_eof = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit sq_empty();
    for (int i = 0; i < NS; i++) if (sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_frame(input int src, input int len);
    logic [8:0] w;
    for (int b = 0; b < len; b++) begin
      w = {(b == len - 1), 2'(src), 3'(fr_id), 3'(b)};
      sq[src].push_back(w);
      exp_q.push_back(w);
    end
    fr_id++;
  endtask

  // Source models: present queue heads, retire accepted beats.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NS; i++) begin
      if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      if (sq[i].size() > 0) begin
        src_valid[i] = 1'b1;
        src_data[i*DB +: DB] = sq[i][0][7:0];
        src_eof[i] = sq[i][0][8];
      end else begin
        src_valid[i] = 1'b0;
        src_eof[i] = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      fire = '0;
      prev_eof = 1'b0;
    end else begin
      if (prev_eof) begin
        chk("bubble_valid", 32'(dout_valid), 32'd0);
        chk("bubble_ready", 32'(src_ready), 32'd0);
      end
      if (dout_valid)
        chk("ready_mirror", 32'(src_ready),
            dout_ready ? 32'(4'(1) << dout_data[7:6]) : 32'd0);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0)
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        else
          chk("beat", 32'({dout_eof, dout_data}), 32'(exp_q.pop_front()));
      end
      prev_eof = dout_valid & dout_ready & dout_eof;
      fire = src_valid & src_ready;
    end
  end

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_paddr = a; cfg_pwrite = 1'b1; cfg_pwdata = d;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cfg_paddr = a; cfg_pwrite = 1'b0;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    d = cfg_prdata;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a,
                        input logic [31:0] expv);
    logic [31:0] d;
    apb_rd(a, d);
    chk(tag, d, expv);
  endtask

  task automatic drain(input string tag);
    int ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && sq_empty() && !dout_valid) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int ok;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_irq", 32'(cfg_irq), 32'd0);
    chk("rst_prdata", cfg_prdata, 32'd0);
    rd_chk("rst_enable", 5'd0, 32'hF);
    rd_chk("rst_status", 5'd4, 32'd0);
    rd_chk("rst_irq_reg", 5'd8, 32'd0);
    rd_chk("rst_last", 5'd12, 32'd0);
    rd_chk("rst_fcnt0", 5'd16, 32'd0);

    // All sources streaming: order 0,1,2,3,0,1,2,3
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NS; i++) push_frame(i, i + 1);
    drain("rr_drain");
    for (int i = 0; i < NS; i++)
      rd_chk($sformatf("rr_fcnt%0d", i), 5'(16 + 4 * i), 32'd2);
    rd_chk("rr_last", 5'd12, 32'd3);

    // src0 and src2 contend, src0 wins first
    push_frame(0, 3);
    push_frame(2, 3);
    drain("pair_drain");
    rd_chk("pair_fcnt0", 5'd16, 32'd3);
    rd_chk("pair_fcnt1", 5'd20, 32'd2);
    rd_chk("pair_fcnt2", 5'd24, 32'd3);
    rd_chk("pair_last", 5'd12, 32'd2);
    rd_chk("pair_irq", 5'd8, 32'd1);
    chk("pair_irq_pin", 32'(cfg_irq), 32'd1);

    // Only src1 enabled while everyone requests
    apb_wr(5'd0, 32'h2);
    push_frame(1, 2);
    push_frame(1, 2);
    push_frame(2, 2);
    push_frame(3, 2);
    push_frame(0, 2);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("mask_ready", 32'(src_ready & 4'b1101), 32'd0);
      if (sq[1].size() == 0 && !dout_valid) begin
        ok = 1;
        break;
      end
    end
    chk("mask_src1_done", 32'(ok), 32'd1);
    rd_chk("mask_fcnt1", 5'd20, 32'd4);
    rd_chk("mask_fcnt3", 5'd28, 32'd2);
    apb_wr(5'd0, 32'hF);
    drain("mask_drain");

    // Backpressure on a src3 frame
    push_frame(3, 6);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      dout_ready = ~dout_ready;
      if (sq[3].size() == 0) break;
    end
    dout_ready = 1'b1;
    drain("bp_drain");
    rd_chk("bp_fcnt3", 5'd28, 32'd4);

    // irq clear coincides with eof accept: set wins
    @(posedge clk); #1;
    dout_ready = 1'b0;
    push_frame(0, 1);
    repeat (4) @(posedge clk);
    #1;
    dout_ready = 1'b1;
    cfg_paddr = 5'd8; cfg_pwrite = 1'b1; cfg_pwdata = 32'd0;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
    drain("irq_drain");
    rd_chk("irq_set_wins", 5'd8, 32'd1);
    chk("irq_set_pin", 32'(cfg_irq), 32'd1);
    apb_wr(5'd8, 32'd0);
    rd_chk("irq_cleared", 5'd8, 32'd0);
    chk("irq_clear_pin", 32'(cfg_irq), 32'd0);
    rd_chk("irq_last", 5'd12, 32'd0);
    rd_chk("irq_fcnt0", 5'd16, 32'd5);

    // Reset in the middle of a src1 frame
    apb_wr(5'd0, 32'h3);
    push_frame(1, 5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mrst_src_ready", 32'(src_ready), 32'd0);
    chk("mrst_prdata", cfg_prdata, 32'd0);
    apb_rd(5'd4, d);
    chk("mrst_busy", d & 32'd1, 32'd0);
    rd_chk("mrst_enable", 5'd0, 32'hF);
    for (int i = 0; i < NS; i++)
      rd_chk($sformatf("mrst_fcnt%0d", i), 5'(16 + 4 * i), 32'd0);
    push_frame(0, 2);
    push_frame(1, 2);
    drain("mrst_drain");
    rd_chk("mrst_last", 5'd12, 32'd1);
    rd_chk("mrst_fcnt1", 5'd20, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
